noc_receiver: RTL
=================

Name: noc_receiver

Overview:
Terminating end of the NoC link at a core or memory port. It accepts packed flits from the local router output, checks them against the node ID, and decodes the fields. It pairs split TYPE_RESPONSE_ADDR/TYPE_RESPONSE_DATA flits back into one address+data record. Records are buffered in a small FIFO and delivered to the consumer over a valid/ready handshake, with backpressure to the router.

Parameters:
NEXTHOPWIDTH, 3, next-hop field width
DESTWIDTH, 4, destination field width
DATA_SRCWIDTH, 4, source field width
DATA_TYPEWIDTH, 7, type field width
DATA_DWIDTH, 32, data field width
DATA_AWIDTH, 32, address field width
IO_WIDTH, 85, flit width = 2+NEXTHOPWIDTH+1+DESTWIDTH+DATA_SRCWIDTH+DATA_TYPEWIDTH+DATA_DWIDTH+DATA_AWIDTH
MY_ID, 0, this node's destination ID
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
in_flit  in  IO_WIDTH  flit, MSB->LSB {sendokbit, sendbit, nhop, lastbit, dest, src, type, data, addr}
in_ok  out  1  receiver can accept a flit this cycle
rx_valid  out  1  record available
rx_ready  in  1  consumer accepts record
rx_type  out  DATA_TYPEWIDTH  record type
rx_src  out  DATA_SRCWIDTH  record source
rx_addr  out  DATA_AWIDTH  record address
rx_data  out  DATA_DWIDTH  record data
rx_last  out  1  lastbit of the final flit of the record
err_pulse  out  1  one-cycle pulse on any protocol error
drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, pair registers 0, drop_cnt 0, err_pulse 0, rx_valid 0, in_ok 1; rx_* payload outputs 0.
- Flit valid = sendbit field. Flit accepted when sendbit=1 and in_ok=1. sendokbit and nhop fields are ignored. With in_ok=0 the flit is not consumed; the router holds it.
- in_ok = (FIFO count < FIFO_DEPTH), driven from registers only, independent of rx_ready.
- Filter on accepted flits, in this order:
  - dest != MY_ID: drop, drop_cnt+1, no err.
  - type > 7'b0000101: drop, drop_cnt+1, err_pulse.
- TYPE_REQUEST, TYPE_C_REQ, TYPE_WRITE, TYPE_OUTSTANDING: push one record {type, src, addr, data, lastbit}. Valid in either state; state unchanged.
- Pairing FSM:
  - IDLE + RESPONSE_ADDR: latch addr and src into pair registers, go to WAIT_DATA, no push.
  - WAIT_DATA + RESPONSE_DATA with src == latched src: push {TYPE_RESPONSE_DATA, src, latched addr, flit data, flit lastbit}, go to IDLE.
  - WAIT_DATA + RESPONSE_ADDR: overwrite pair registers, err_pulse, drop_cnt+1 for the orphaned address, stay in WAIT_DATA.
  - RESPONSE_DATA in IDLE, or with src != latched src: drop, drop_cnt+1, err_pulse, state unchanged.
- Pairing-step rule: a pairing step that must push needs the push to succeed. It is only taken when the flit is accepted, and acceptance already guarantees a free entry.
- FIFO: show-ahead. rx_* outputs show the head entry, registered. A flit accepted at edge N appears with rx_valid=1 after edge N (latency 1).
- Pop on rx_valid & rx_ready. Push and pop in the same cycle when full: the pop frees no slot for that cycle because in_ok was already 0, so there is no push. When neither empty nor full, push and pop together leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- rx_* payload holds its value while rx_valid=1 and rx_ready=0. Payload when rx_valid=0 is don't-care.
- drop_cnt saturates at 255. err_pulse is registered and high for exactly the cycle after the offending flit's edge.

Test Plan:
- Single WRITE: dest=MY_ID, src=3, addr=0x100, data=0xDEADBEEF, last=1, rx_ready=1 -> next cycle rx_valid=1, rx_type=4, rx_addr=0x100, rx_data=0xDEADBEEF, rx_last=1; popped after one cycle.
- Pairing: RESPONSE_ADDR(src=2, addr=0x40), then REQUEST(src=5), then RESPONSE_DATA(src=2, data=0x1234) -> REQUEST record first, then {type=2, src=2, addr=0x40, data=0x1234}; err_pulse never high.
- Errors: RESPONSE_DATA in IDLE, then dest=MY_ID+1, then type=7'd9 -> no records; drop_cnt=3; err_pulse high twice (first and third flit only).
- Backpressure: rx_ready=0, 5 REQUEST flits offered back-to-back, FIFO_DEPTH=4 -> in_ok=0 after the 4th acceptance; the 5th flit is held; raising rx_ready drains records in order 1-5 with none lost.
- Orphan address: RESPONSE_ADDR(0x10), RESPONSE_ADDR(0x20), RESPONSE_DATA(0x77), same src -> one record with addr=0x20, data=0x77; err_pulse once; drop_cnt=1.
- Async reset while WAIT_DATA with 2 FIFO entries queued -> rx_valid=0, in_ok=1, drop_cnt=0 immediately; a following RESPONSE_DATA is dropped as an IDLE error.

Source files
------------

// File: rtl/noc_receiver.sv
// NoC link terminator: filters flits by node ID, pairs split response addr/data
// flits into one record, and queues records to a valid/ready consumer.
module noc_receiver #(
  parameter int NEXTHOPWIDTH   = 3,
  parameter int DESTWIDTH      = 4,
  parameter int DATA_SRCWIDTH  = 4,
  parameter int DATA_TYPEWIDTH = 7,
  parameter int DATA_DWIDTH    = 32,
  parameter int DATA_AWIDTH    = 32,
  parameter int IO_WIDTH       = 85,
  parameter int MY_ID          = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IO_WIDTH-1:0]       in_flit,
  output logic                      in_ok,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [DATA_TYPEWIDTH-1:0] rx_type,
  output logic [DATA_SRCWIDTH-1:0]  rx_src,
  output logic [DATA_AWIDTH-1:0]    rx_addr,
  output logic [DATA_DWIDTH-1:0]    rx_data,
  output logic                      rx_last,
  output logic                      err_pulse,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = DATA_TYPEWIDTH + DATA_SRCWIDTH + DATA_AWIDTH + DATA_DWIDTH + 1;

  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned DATA_LSB   = ADDR_LSB + DATA_AWIDTH;
  localparam int unsigned TYPE_LSB   = DATA_LSB + DATA_DWIDTH;
  localparam int unsigned SRC_LSB    = TYPE_LSB + DATA_TYPEWIDTH;
  localparam int unsigned DEST_LSB   = SRC_LSB + DATA_SRCWIDTH;
  localparam int unsigned LAST_BIT   = DEST_LSB + DESTWIDTH;
  localparam int unsigned NHOP_LSB   = LAST_BIT + 1;
  localparam int unsigned SEND_BIT   = NHOP_LSB + NEXTHOPWIDTH;
  localparam int unsigned SENDOK_BIT = SEND_BIT + 1;

  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_REQUEST       = DATA_TYPEWIDTH'(0);
  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_RESPONSE_ADDR = DATA_TYPEWIDTH'(1);
  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_RESPONSE_DATA = DATA_TYPEWIDTH'(2);
  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_C_REQ         = DATA_TYPEWIDTH'(3);
  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_WRITE         = DATA_TYPEWIDTH'(4);
  localparam logic [DATA_TYPEWIDTH-1:0] TYPE_OUTSTANDING   = DATA_TYPEWIDTH'(5);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t state_q, state_d;

  logic [DATA_AWIDTH-1:0]    f_addr;
  logic [DATA_DWIDTH-1:0]    f_data;
  logic [DATA_TYPEWIDTH-1:0] f_type;
  logic [DATA_SRCWIDTH-1:0]  f_src;
  logic [DESTWIDTH-1:0]      f_dest;
  logic                      f_last;
  logic                      f_send;
  logic                      unused_fields;

  assign f_addr = in_flit[ADDR_LSB +: DATA_AWIDTH];
  assign f_data = in_flit[DATA_LSB +: DATA_DWIDTH];
  assign f_type = in_flit[TYPE_LSB +: DATA_TYPEWIDTH];
  assign f_src  = in_flit[SRC_LSB +: DATA_SRCWIDTH];
  assign f_dest = in_flit[DEST_LSB +: DESTWIDTH];
  assign f_last = in_flit[LAST_BIT];
  assign f_send = in_flit[SEND_BIT];
  assign unused_fields = ^{in_flit[SENDOK_BIT], in_flit[NHOP_LSB +: NEXTHOPWIDTH]};

  logic accept, dest_ok, type_ok, src_match;
  assign accept    = f_send & in_ok;
  assign dest_ok   = (f_dest == DESTWIDTH'(MY_ID));
  assign type_ok   = (f_type <= TYPE_OUTSTANDING);

  logic [DATA_AWIDTH-1:0]   pair_addr_q;
  logic [DATA_SRCWIDTH-1:0] pair_src_q;
  assign src_match = (f_src == pair_src_q);

  logic          push, drop, err, latch;
  logic [RW-1:0] push_rec;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: only valid, addressed response flits move the pairing FSM
  always_comb begin
    state_d = state_q;
    if (accept && dest_ok && type_ok) begin
      if (f_type == TYPE_RESPONSE_ADDR) begin
        state_d = WAIT_DATA;
      end else if (f_type == TYPE_RESPONSE_DATA && state_q == WAIT_DATA && src_match) begin
        state_d = IDLE;
      end
    end
  end

  // Per-flit decode: push / drop / error / pair-latch strobes
  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    err      = 1'b0;
    latch    = 1'b0;
    push_rec = {f_type, f_src, f_addr, f_data, f_last};
    if (accept) begin
      if (!dest_ok) begin
        drop = 1'b1;
      end else if (!type_ok) begin
        drop = 1'b1;
        err  = 1'b1;
      end else begin
        case (f_type)
          TYPE_REQUEST, TYPE_C_REQ, TYPE_WRITE, TYPE_OUTSTANDING: push = 1'b1;
          TYPE_RESPONSE_ADDR: begin
            latch = 1'b1;
            if (state_q == WAIT_DATA) begin
              drop = 1'b1;
              err  = 1'b1;
            end
          end
          TYPE_RESPONSE_DATA: begin
            if (state_q == WAIT_DATA && src_match) begin
              push     = 1'b1;
              push_rec = {TYPE_RESPONSE_DATA, f_src, pair_addr_q, f_data, f_last};
            end else begin
              drop = 1'b1;
              err  = 1'b1;
            end
          end
          default: begin
            drop = 1'b1;
            err  = 1'b1;
          end
        endcase
      end
    end
  end

  // Pair registers, drop counter and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_addr_q <= '0;
      pair_src_q  <= '0;
      drop_cnt    <= '0;
      err_pulse   <= 1'b0;
    end else begin
      if (latch) begin
        pair_addr_q <= f_addr;
        pair_src_q  <= f_src;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      err_pulse <= err;
    end
  end

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] head_q, head_d;
  logic          pop;

  assign pop = rx_valid & rx_ready;

  // Next head is the pushed record only when it lands in an otherwise empty queue
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    head_d   = (push && wr_ptr_q == rd_ptr_d) ? push_rec : mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      rx_valid <= 1'b0;
      in_ok    <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      rx_valid <= (count_d != '0);
      in_ok    <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  assign {rx_type, rx_src, rx_addr, rx_data, rx_last} = head_q;

endmodule
